riscv1stage_fetch_unit: RTL
===========================

RISCV1STAGE_FETCH_UNIT -- requirements
Module: riscv1stage_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC loaded on reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h00000100, redirect target for the exception select or a misaligned target.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 pcSelect  input  3  next-PC select from control: 0=pc_4, 1=branch, 2=jump, 3=jalr, 4=exception, 5-7 treated as exception.
REQ-007 branchTarget  input  32  PC-relative branch target.
REQ-008 jumpTarget  input  32  JAL target.
REQ-009 jalrTarget  input  32  rs1+imm from ALU, raw.
REQ-010 retire  input  1  current instruction consumed this cycle; pcSelect and targets are sampled.
REQ-011 imemReqValid  output  1  instruction memory request valid.
REQ-012 imemReqReady  input  1  memory accepts request.
REQ-013 imemAddress  output  32  request address, equal to pc.
REQ-014 imemRespValid  input  1  response data valid.
REQ-015 imemRespData  input  32  fetched instruction word.
REQ-016 instruction  output  32  held instruction to control and decode.
REQ-017 instructionValid  output  1  instruction register holds a live instruction.
REQ-018 pc  output  32  address of the held instruction.
REQ-019 pcPlus4  output  32  pc+4, for link writeback.
REQ-020 fetchMisaligned  output  1  one-cycle pulse on misaligned redirect.

Function
REQ-021 SHALL implement the FSM IDLE -> REQ -> WAIT -> VALID -> REQ.
- IDLE: always go to REQ next cycle.
- REQ: imemReqValid=1; go to WAIT on imemReqReady.
- WAIT: hold until imemRespValid; then latch imemRespData into instruction and go to VALID.
- VALID: instructionValid=1; on retire, load pc with the next PC and go to REQ.
REQ-022 imemReqValid and instructionValid SHALL be decoded from the state only, asserted solely in REQ and VALID respectively.
REQ-023 imemAddress SHALL equal pc at all times; pc SHALL change only on a retire in VALID, or on reset.
REQ-024 Next-PC rules:
- pc_4: pc+4, mod 2^32 (32'hFFFFFFFC wraps to 0).
- branch: branchTarget.
- jump: jumpTarget.
- jalr: {jalrTarget[31:1],1'b0}.
- exception or codes 5-7: TRAP_VECTOR.
REQ-025 If the selected next PC has bits [1:0] != 0, the block SHALL load TRAP_VECTOR instead and assert fetchMisaligned for exactly the following cycle.
REQ-026 pcPlus4 SHALL be combinational pc+4 with 32-bit wrap.
REQ-027 imemRespValid SHALL be ignored outside WAIT.
REQ-028 retire SHALL be ignored outside VALID; pcSelect and targets are don't-care then.
REQ-029 If imemReqReady is held low, the block SHALL stay in REQ with imemAddress stable.
REQ-030 Minimum fetch-to-valid latency SHALL be 2 cycles: accept in cycle N, response in N+1, instructionValid in N+2.
REQ-031 instruction SHALL hold its value from the latch until the next response is latched, including through REQ and WAIT.

Reset
REQ-032 On clk edge with rst_n=0, from any state (including WAIT with a response outstanding):
- state=IDLE, pc=RESET_PC, instruction=32'h00000013 (NOP).
- instructionValid=0, imemReqValid=0, fetchMisaligned=0.
REQ-033 A response arriving after reset, before the first new request is accepted, SHALL be discarded.

Verification
REQ-034 Reset release, imemReqReady=1, response one cycle after accept with 32'h00500093 -> first request at imemAddress=0x0; instruction=32'h00500093, pc=0, pcPlus4=4 and instructionValid=1 two cycles after accept.
REQ-035 Retire with pcSelect=0 three times -> imemAddress sequence 0x0, 0x4, 0x8, 0xC.
REQ-036 At pc=0x10, retire with pcSelect=3 and jalrTarget=32'h00000201 -> next request at 0x200, fetchMisaligned stays 0.
REQ-037 Retire with pcSelect=1 and branchTarget=32'h00000106 -> next request at 0x100, and fetchMisaligned=1 for one cycle.
REQ-038 imemReqReady held low 5 cycles in REQ -> imemReqValid=1 and address stable throughout; then rst_n=0 in WAIT followed by a stale response -> instruction=32'h00000013, next request at RESET_PC.
REQ-039 At pc=32'hFFFFFFFC, retire with pcSelect=0 -> pc wraps to 0, pcPlus4 at pc=32'hFFFFFFFC reads 0; pcSelect=6 -> request at TRAP_VECTOR.

Source files
------------

// File: rtl/riscv1stage_fetch_unit.sv
// Instruction fetch unit for a single-issue RISC-V core: owns the PC, issues one
// instruction-memory request at a time and holds the returned word for decode.
module riscv1stage_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h00000000,
  parameter logic [31:0] TRAP_VECTOR = 32'h00000100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pcSelect,
  input  logic [31:0] branchTarget,
  input  logic [31:0] jumpTarget,
  input  logic [31:0] jalrTarget,
  input  logic        retire,
  output logic        imemReqValid,
  input  logic        imemReqReady,
  output logic [31:0] imemAddress,
  input  logic        imemRespValid,
  input  logic [31:0] imemRespData,
  output logic [31:0] instruction,
  output logic        instructionValid,
  output logic [31:0] pc,
  output logic [31:0] pcPlus4,
  output logic        fetchMisaligned
);

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_misaligned;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_sel_pc;
  logic        w_misaligned;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Unused select codes fall through to the trap vector, same as an exception.
  always_comb begin
    w_sel_pc = TRAP_VECTOR;
    case (pcSelect)
      3'd0:    w_sel_pc = w_pc_plus4;
      3'd1:    w_sel_pc = branchTarget;
      3'd2:    w_sel_pc = jumpTarget;
      3'd3:    w_sel_pc = {jalrTarget[31:1], 1'b0};
      default: w_sel_pc = TRAP_VECTOR;
    endcase
    w_misaligned = (w_sel_pc[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= NOP;
      r_misaligned <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imemReqReady) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imemRespValid) begin
            r_instr <= imemRespData;
            r_state <= S_VALID;
          end
        end
        S_VALID: begin
          if (retire) begin
            r_pc         <= w_misaligned ? TRAP_VECTOR : w_sel_pc;
            r_misaligned <= w_misaligned;
            r_state      <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imemReqValid     = (r_state == S_REQ);
  assign instructionValid = (r_state == S_VALID);
  assign imemAddress      = r_pc;
  assign pc               = r_pc;
  assign pcPlus4          = w_pc_plus4;
  assign instruction      = r_instr;
  assign fetchMisaligned  = r_misaligned;

endmodule
